// File: rtl/axis_sram_streamer.sv
// SRAM-to-AXI4-Stream reader: issues credit-limited SRAM reads into a small prefetch
// FIFO and streams the words out with a rotating channel tag in tuser and a configurable tlast.
module axis_sram_streamer #(
  parameter int ADDR_WIDTH         = 13,
  parameter int TDATA_WIDTH        = 16,
  parameter int MAX_ADDR_WIDTH     = ADDR_WIDTH + 1,
  parameter int NUM_CHANNELS_WIDTH = $clog2(64 + 1),
  parameter int RD_LAT             = 1,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                          m_axis_aclk,
  input  logic                          m_axis_areset,
  input  logic                          start,
  input  logic [ADDR_WIDTH-1:0]         base_addr,
  input  logic [MAX_ADDR_WIDTH-1:0]     out_size,
  input  logic [NUM_CHANNELS_WIDTH-1:0] num_channels,
  input  logic                          tlast_per_group,
  output logic                          busy,
  output logic                          done,
  output logic                          sram_out_en,
  output logic [ADDR_WIDTH-1:0]         sram_out_addr,
  input  logic [TDATA_WIDTH-1:0]        sram_out_data_out,
  output logic [TDATA_WIDTH-1:0]        m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [NUM_CHANNELS_WIDTH-1:0] m_axis_tuser
);

  localparam int NCW = NUM_CHANNELS_WIDTH;
  localparam int SW  = MAX_ADDR_WIDTH;
  localparam int CW  = $clog2(FIFO_DEPTH + RD_LAT + 3) + 1;
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, nxt_addr_q;
  logic [SW-1:0]          size_q, issued_q, sent_q;
  logic [NCW-1:0]         nch_q, chan_q;
  logic                   pg_q, en_q;
  logic [RD_LAT:1]        ret_q;
  logic [TDATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]          wr_q, rd_q;
  logic [CW-1:0]          cnt_q, inflight;
  logic                   issue, push, pop, tvalid_w;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // ret_q[k] marks a read enabled k cycles ago; the last stage lines up with valid read data.
  always_comb begin
    inflight = CW'(en_q);
    for (int k = 1; k <= RD_LAT; k++) inflight = inflight + CW'(ret_q[k]);
  end

  assign push     = ret_q[RD_LAT];
  assign tvalid_w = (cnt_q != '0);
  assign pop      = tvalid_w && m_axis_tready;
  // Credit check: every enabled or returning read already owns a FIFO slot.
  assign issue    = (state_q == S_RUN) && (issued_q != size_q) &&
                    (cnt_q + inflight + CW'(1) <= CW'(FIFO_DEPTH) + CW'(pop));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (out_size == '0) ? S_DONE : S_RUN;
      S_RUN:   if (issued_q == size_q) state_d = S_DRAIN;
      S_DRAIN: if (inflight == '0 && (cnt_q == '0 || (cnt_q == CW'(1) && pop)))
                 state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
    if (m_axis_areset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      nxt_addr_q <= '0;
      size_q     <= '0;
      issued_q   <= '0;
      sent_q     <= '0;
      nch_q      <= NCW'(1);
      chan_q     <= '0;
      pg_q       <= 1'b0;
      en_q       <= 1'b0;
      ret_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        nxt_addr_q <= base_addr;
        size_q     <= out_size;
        nch_q      <= (num_channels == '0) ? NCW'(1) : num_channels;
        pg_q       <= tlast_per_group;
        issued_q   <= '0;
        sent_q     <= '0;
        chan_q     <= '0;
      end
      en_q <= issue;
      if (issue) begin
        addr_q     <= nxt_addr_q;
        nxt_addr_q <= nxt_addr_q + ADDR_WIDTH'(1);
        issued_q   <= issued_q + SW'(1);
      end
      ret_q[1] <= en_q;
      for (int k = 2; k <= RD_LAT; k++) ret_q[k] <= ret_q[k-1];
      if (push) begin
        mem_q[wr_q] <= sram_out_data_out;
        wr_q        <= ptr_inc(wr_q);
      end
      if (pop) begin
        rd_q   <= ptr_inc(rd_q);
        sent_q <= sent_q + SW'(1);
        chan_q <= (chan_q == nch_q - NCW'(1)) ? '0 : chan_q + NCW'(1);
      end
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  assign busy          = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done          = (state_q == S_DONE);
  assign sram_out_en   = en_q;
  assign sram_out_addr = addr_q;
  assign m_axis_tvalid = tvalid_w;
  assign m_axis_tdata  = tvalid_w ? mem_q[rd_q] : '0;
  assign m_axis_tuser  = tvalid_w ? chan_q : '0;
  assign m_axis_tlast  = tvalid_w && ((sent_q == size_q - SW'(1)) ||
                                      (pg_q && chan_q == nch_q - NCW'(1)));

endmodule

// File: tb/tb_axis_sram_streamer.sv
// Directed bench for axis_sram_streamer: one default instance (RD_LAT=1) and one deep
// instance (RD_LAT=3, FIFO_DEPTH=5) share stimulus; a selector picks whose outputs are checked.
module tb_axis_sram_streamer;
  localparam int AW = 13, DW = 16, SW = 14, CWD = 7;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic           start = 1'b0, pg = 1'b0, tready = 1'b0;
  logic [AW-1:0]  base = '0;
  logic [SW-1:0]  size = '0;
  logic [CWD-1:0] nch = '0;

  logic a_busy, a_done, a_en, a_tvalid, a_tlast, b_busy, b_done, b_en, b_tvalid, b_tlast;
  logic [AW-1:0]  a_addr, b_addr;
  logic [DW-1:0]  a_din, b_din, a_tdata, b_tdata;
  logic [CWD-1:0] a_tuser, b_tuser;

  axis_sram_streamer u_a (
    .m_axis_aclk(clk), .m_axis_areset(rst), .start(start), .base_addr(base),
    .out_size(size), .num_channels(nch), .tlast_per_group(pg), .busy(a_busy),
    .done(a_done), .sram_out_en(a_en), .sram_out_addr(a_addr), .sram_out_data_out(a_din),
    .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid), .m_axis_tready(tready),
    .m_axis_tlast(a_tlast), .m_axis_tuser(a_tuser));

  axis_sram_streamer #(.RD_LAT(3), .FIFO_DEPTH(5)) u_b (
    .m_axis_aclk(clk), .m_axis_areset(rst), .start(start), .base_addr(base),
    .out_size(size), .num_channels(nch), .tlast_per_group(pg), .busy(b_busy),
    .done(b_done), .sram_out_en(b_en), .sram_out_addr(b_addr), .sram_out_data_out(b_din),
    .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid), .m_axis_tready(tready),
    .m_axis_tlast(b_tlast), .m_axis_tuser(b_tuser));

  function automatic logic [DW-1:0] f(input logic [AW-1:0] a);
    return (DW'(a) * 16'd3) ^ 16'h5A5A;
  endfunction

  // SRAM models: address pipeline, data RD_LAT cycles after the enable cycle
  logic [AW-1:0] pa [3];
  logic [AW-1:0] pb [3];
  always @(posedge clk) begin
    pa[0] <= a_addr; pa[1] <= pa[0]; pa[2] <= pa[1];
    pb[0] <= b_addr; pb[1] <= pb[0]; pb[2] <= pb[1];
  end
  assign a_din = f(pa[0]);
  assign b_din = f(pb[2]);

  logic sel = 1'b0;
  logic o_busy, o_done, o_en, o_tvalid, o_tlast;
  logic [AW-1:0] o_addr; logic [DW-1:0] o_tdata; logic [CWD-1:0] o_tuser;
  assign o_busy   = sel ? b_busy   : a_busy;
  assign o_done   = sel ? b_done   : a_done;
  assign o_en     = sel ? b_en     : a_en;
  assign o_addr   = sel ? b_addr   : a_addr;
  assign o_tvalid = sel ? b_tvalid : a_tvalid;
  assign o_tdata  = sel ? b_tdata  : a_tdata;
  assign o_tlast  = sel ? b_tlast  : a_tlast;
  assign o_tuser  = sel ? b_tuser  : a_tuser;

  int checks = 0, errors = 0, a_done_cnt = 0;
  always @(negedge clk) if (a_done) a_done_cnt++;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic rdy(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    return (cyc % 4 == 0) || (cyc % 4 == 3);
  endfunction

  typedef struct {
    logic [AW-1:0] base;
    int            size;
    int            nch;
    bit            pg;
    int            mode;
    bit            usb;
  } vec_t;

  task automatic wait_idle();
    tready = 1'b1;
    for (int i = 0; i < 300 && (a_busy || b_busy || a_done || b_done); i++) @(negedge clk);
    if (a_busy || b_busy) chk("idle_timeout", 0, 1);
  endtask

  task automatic run(input vec_t v);
    int beats = 0, nen = 0, first = -1, last_hs = -1, nche, dep, lat, eu;
    bit stalled = 0, fin = 0, el;
    logic [DW-1:0] hd; logic [CWD-1:0] hu; logic hl;
    logic [AW-1:0] ea;
    nche = (v.nch == 0) ? 1 : v.nch;
    dep  = v.usb ? 5 : 4;
    lat  = v.usb ? 5 : 3;
    wait_idle();
    sel = v.usb;
    @(negedge clk);
    base = v.base; size = SW'(v.size); nch = CWD'(v.nch); pg = v.pg; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; tready = rdy(v.mode, 0);
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      if (cyc > 0) begin @(posedge clk); #1 tready = rdy(v.mode, cyc); end
      @(negedge clk);
      if (cyc == 0) chk("busy_after_start", o_busy, v.size != 0);
      if (o_en) begin
        ea = v.base + AW'(nen);
        chk("sram_addr", o_addr, ea);
        nen++;
      end
      if (nen - beats > dep) chk("outstanding_reads", nen - beats, dep);
      if (o_tvalid) begin
        if (first < 0) begin
          first = cyc;
          if (v.mode == 0) chk("first_tvalid_latency", cyc, lat);
        end
        if (stalled) begin
          chk("tdata_stable", o_tdata, hd);
          chk("tuser_stable", o_tuser, hu);
          chk("tlast_stable", o_tlast, hl);
        end
        if (tready) begin
          ea = v.base + AW'(beats);
          eu = beats % nche;
          el = (beats == v.size - 1) || (v.pg && eu == nche - 1);
          chk("tdata", o_tdata, f(ea));
          chk("tuser", o_tuser, eu);
          chk("tlast", o_tlast, el);
          beats++;
          last_hs = cyc;
        end
      end else begin
        if (stalled) chk("tvalid_held_while_stalled", o_tvalid, 1);
        if (v.mode == 0 && beats > 0 && beats < v.size) chk("no_bubble_tvalid", o_tvalid, 1);
      end
      stalled = o_tvalid && !tready;
      hd = o_tdata; hu = o_tuser; hl = o_tlast;
      if (o_done) begin
        chk("done_cycle", cyc, (v.size == 0) ? 0 : last_hs + 1);
        chk("beat_count", beats, v.size);
        chk("read_count", nen, v.size);
        chk("busy_low_at_done", o_busy, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("done_single_cycle", o_done, 0);
        fin = 1;
      end
    end
    if (!fin) chk("done_timeout", 0, 1);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_a"}, {a_busy, a_done, a_en, a_addr, a_tvalid, a_tdata, a_tlast, a_tuser}, 0);
    chk({nm, "_b"}, {b_busy, b_done, b_en, b_addr, b_tvalid, b_tdata, b_tlast, b_tuser}, 0);
  endtask

  vec_t vt [7];
  int   beats, dc0;

  initial begin
    vt[0] = '{13'h0010,  8, 4, 1'b1, 0, 1'b0};
    vt[1] = '{13'h0010,  8, 4, 1'b1, 1, 1'b0};
    vt[2] = '{13'h0020,  0, 4, 1'b1, 0, 1'b0};
    vt[3] = '{13'h1FFE,  4, 4, 1'b0, 0, 1'b0};
    vt[4] = '{13'h0100, 64, 5, 1'b1, 0, 1'b1};
    vt[5] = '{13'h1FFE,  6, 3, 1'b1, 1, 1'b1};
    vt[6] = '{13'h0005,  3, 0, 1'b1, 0, 1'b0};

    repeat (2) @(negedge clk);
    chk_reset_outputs("reset_outputs");
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run(vt[i]);

    // mid-stream reset after beat 2, then a fresh 2-beat stream
    wait_idle();
    sel = 1'b0;
    @(negedge clk);
    base = 13'h0040; size = SW'(16); nch = CWD'(4); pg = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    beats = 0;
    for (int i = 0; i < 100 && beats < 3; i++) begin
      @(negedge clk);
      if (a_done) chk("no_done_before_reset", a_done, 0);
      if (a_tvalid) beats++;
    end
    chk("beats_before_reset", beats, 3);
    dc0 = a_done_cnt;
    @(posedge clk);
    #1 rst = 1'b1;
    #1 chk_reset_outputs("async_reset_outputs");
    @(negedge clk);
    chk_reset_outputs("held_reset_outputs");
    @(negedge clk);
    rst = 1'b0;
    run('{13'h0200, 2, 3, 1'b1, 0, 1'b0});
    repeat (3) @(negedge clk);
    chk("done_pulses_after_reset", a_done_cnt - dc0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
